// File: rtl/bw_div_pkg.sv
// Shared types and constants for the bw_divider restoring divider.
package bw_div_pkg;

    localparam int default_width_p = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bw_div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference when it does not borrow.
module bw_div_step #(
    parameter int width_p = 4
) (
    input  logic [width_p:0]   rem_i,
    input  logic [width_p-1:0] div_i,
    output logic [width_p-1:0] rem_o,
    output logic               q_bit_o
);

    logic [width_p:0] diff;

    // The top difference bit is a valid borrow because rem_i < 2*div_i holds for a
    // nonzero divisor; a zero divisor is resolved by the caller.
    assign diff    = rem_i - {1'b0, div_i};
    assign q_bit_o = ~diff[width_p];
    assign rem_o   = q_bit_o ? diff[width_p-1:0] : rem_i[width_p-1:0];

endmodule

// File: rtl/bw_divider.sv
// Sequential signed/unsigned divider: magnitudes go through width_p restoring
// steps, then quotient and remainder signs are fixed up on entry to DONE.
module bw_divider
    import bw_div_pkg::*;
#(
    parameter int width_p = default_width_p
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic               a_signed_i,
    input  logic               b_signed_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] q_o,
    output logic [width_p-1:0] r_o,
    output logic               div_zero_o
);

    localparam int cnt_w = $clog2(width_p + 1);

    state_t             state;
    logic [cnt_w-1:0]   cnt;
    logic [width_p-1:0] a_raw;
    logic [width_p-1:0] divisor;
    logic [width_p-1:0] quo;
    logic [width_p-1:0] rem;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;

    logic               a_in_neg;
    logic               b_in_neg;
    logic [width_p-1:0] a_mag;
    logic [width_p-1:0] b_mag;
    logic [width_p-1:0] step_rem;
    logic               step_q;

    // Mod-2^width_p negation also yields the right magnitude for the most-negative value.
    assign a_in_neg = a_signed_i & a_i[width_p-1];
    assign b_in_neg = b_signed_i & b_i[width_p-1];
    assign a_mag    = a_in_neg ? ('0 - a_i) : a_i;
    assign b_mag    = b_in_neg ? ('0 - b_i) : b_i;

    bw_div_step #(
        .width_p (width_p)
    ) u_step (
        .rem_i   ({rem, quo[width_p-1]}),
        .div_i   (divisor),
        .rem_o   (step_rem),
        .q_bit_o (step_q)
    );

    assign ready_o = rst_ni && (state == IDLE);
    assign valid_o = (state == DONE);

    // NOTE: datapath registers are loaded before use, so only control and outputs reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            q_o        <= '0;
            r_o        <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_raw   <= a_i;
                        divisor <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        a_neg   <= a_in_neg;
                        b_neg   <= b_in_neg;
                        b_zero  <= (b_i == '0);
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == cnt_w'(width_p)) begin
                        div_zero_o <= b_zero;
                        if (b_zero) begin
                            q_o <= '1;
                            r_o <= a_raw;
                        end else begin
                            q_o <= (a_neg ^ b_neg) ? ('0 - quo) : quo;
                            r_o <= a_neg ? ('0 - rem) : rem;
                        end
                        state <= DONE;
                    end else begin
                        rem <= step_rem;
                        quo <= (quo << 1) | width_p'(step_q);
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_divider.sv
// Self-checking bench for bw_divider (width_p = 4) against an integer-arithmetic model.
module tb_bw_divider;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       a_signed_i;
    logic       b_signed_i;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] q_o;
    logic [3:0] r_o;
    logic       div_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    bw_divider #(.width_p(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .a_signed_i (a_signed_i),
        .b_signed_i (b_signed_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .q_o        (q_o),
        .r_o        (r_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers and use SV's truncating / and %.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic as, input logic bs,
                         output logic [3:0] q, output logic [3:0] r, output logic dz);
        int av, bv, qi, ri;
        av = (as && a[3]) ? int'(a) - 16 : int'(a);
        bv = (bs && b[3]) ? int'(b) - 16 : int'(b);
        if (bv == 0) begin
            q = 4'hF; r = a; dz = 1'b1;
        end else begin
            qi = av / bv;
            ri = av % bv;
            q  = qi[3:0];
            r  = ri[3:0];
            dz = 1'b0;
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic as, input logic bs,
                         input int hold);
        logic [3:0] eq, er;
        logic       edz;
        int         edges;
        model(a, b, as, bs, eq, er, edz);
        a_i = a; b_i = b; a_signed_i = as; b_signed_i = bs; valid_i = 1'b1;
        #1;
        check("ready_idle", ready_o, 1'b1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        a_i = 4'($urandom); b_i = 4'($urandom);
        a_signed_i = 1'($urandom); b_signed_i = 1'($urandom);
        edges = 0;
        while (!valid_o && edges < 20) begin
            @(posedge clk_i); #1;
            edges++;
        end
        check("latency", edges, 5);
        check("q", q_o, eq);
        check("r", r_o, er);
        check("div_zero", div_zero_o, edz);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check("hold_valid", valid_o, 1'b1);
            check("hold_ready", ready_o, 1'b0);
            check("hold_q", q_o, eq);
            check("hold_r", r_o, er);
            check("hold_dz", div_zero_o, edz);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("back_to_idle", {valid_o, ready_o}, 2'b01);
    endtask

    initial begin
        int rises;
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; a_signed_i = 1'b0; b_signed_i = 1'b0;
        #1;
        check("ready_in_reset", ready_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", {valid_o, q_o, r_o, div_zero_o}, 10'b0);
        check("ready_in_reset2", ready_o, 1'b0);
        rst_ni = 1'b1;
        #1;
        check("ready_after_reset", ready_o, 1'b1);

        do_op(4'b1101, 4'b0100, 1'b0, 1'b0, 0);  // 13/4
        do_op(4'b1001, 4'b0010, 1'b1, 1'b1, 0);  // -7/2
        do_op(4'b1111, 4'b1111, 1'b0, 1'b1, 0);  // 15/-1
        do_op(4'b0110, 4'b0000, 1'b1, 1'b0, 0);  // divide by zero
        do_op(4'b1000, 4'b1111, 1'b1, 1'b1, 0);  // -8/-1
        do_op(4'b0111, 4'b1101, 1'b1, 1'b1, 3);  // 7/-3, consumer stalls

        // Reset two cycles into CALC aborts the operation.
        a_i = 4'b1011; b_i = 4'b0011; a_signed_i = 1'b0; b_signed_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("ready_low_during_reset", ready_o, 1'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;
        check("abort_ready", ready_o, 1'b1);
        check("abort_outputs", {valid_o, q_o, r_o, div_zero_o}, 10'b0);
        rises = 0;
        repeat (8) begin
            @(posedge clk_i); #1;
            if (valid_o) rises++;
        end
        check("abort_no_valid", rises, 0);
        do_op(4'b1011, 4'b0011, 1'b0, 1'b0, 1);

        for (int sc = 0; sc < 4; sc++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_op(4'(a), 4'(b), sc[1], sc[0], 0);

        for (int k = 0; k < 40; k++)
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
